dmem_store_buffer_responder: RTL and testbench

- Data-memory responder at the far end of the memory-write stage's data-memory interface.
- Accepts word stores (mwr/mwa/mwd) and word loads (mre/mra), returns load data combinationally on mrd.
- Models a single-port word array fronted by a posted-write store buffer. The buffer drains into the array on cycles without a load, and forwards pending store data to loads to the same address.

---
 rtl/dmem_store_buffer_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_store_buffer_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer_responder.sv
// Data-memory responder: a single-port word array behind a posted-write store buffer.
// Stores are queued in a FIFO and drain into the array on cycles without a load, or
// whenever the buffer is full. Loads are answered combinationally. A load to an index
// with pending stores is served from the youngest matching buffer entry.
// Optional build macro DMEM_SB_STATS_EN adds saturating load/store/forward counters.
module dmem_store_buffer_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                       clk_46,
  input  logic                       rst_46,
  input  logic                       mwr_d_46,
  input  logic [31:0]                mwa_d_46,
  input  logic [31:0]                mwd_d_46,
  input  logic                       mre_d_46,
  input  logic [31:0]                mra_d_46,
  output logic [31:0]                mrd_d_46,
  output logic [$clog2(SB_DEPTH):0]  sb_count_46,
  output logic                       sb_full_46,
  output logic                       addr_err_46
`ifdef DMEM_SB_STATS_EN
  ,
  output logic [15:0]                ld_cnt_46,
  output logic [15:0]                st_cnt_46,
  output logic [15:0]                fwd_cnt_46
`endif
);

  localparam int unsigned PtrW  = $clog2(SB_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned Words = 2 ** ADDR_W;

  // Word-aligned and no bits set above the word-index field.
  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (ADDR_W + 2)) == 32'd0);
  endfunction

  logic [31:0]       mem_q [Words];
  logic [ADDR_W-1:0] sb_idx_q  [SB_DEPTH];
  logic [31:0]       sb_data_q [SB_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              addr_err_q;

  logic              ld_legal, st_legal;
  logic [ADDR_W-1:0] ld_idx, st_idx;
  logic              sb_full;
  logic              do_load, do_store, do_drain, bad_req;
  logic              fwd_hit;
  logic [31:0]       fwd_data;

  assign ld_legal = addr_legal(mra_d_46);
  assign st_legal = addr_legal(mwa_d_46);
  assign ld_idx   = mra_d_46[ADDR_W+1:2];
  assign st_idx   = mwa_d_46[ADDR_W+1:2];
  assign sb_full  = (count_q == CntW'(SB_DEPTH));

  assign do_load  = !rst_46 && mre_d_46 && ld_legal;
  assign do_store = !rst_46 && mwr_d_46 && st_legal;
  // A full buffer drains even under a load so a concurrent push can never overflow.
  assign do_drain = !rst_46 && (count_q != '0) && (!mre_d_46 || sb_full);
  assign bad_req  = !rst_46 && ((mwr_d_46 && !st_legal) || (mre_d_46 && !ld_legal));

  // Search oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < int'(SB_DEPTH); k++) begin
      if ((CntW'(k) < count_q) && (sb_idx_q[rd_ptr_q + PtrW'(k)] == ld_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_data_q[rd_ptr_q + PtrW'(k)];
      end
    end
  end

  // Load data: forwarded entry, else array word; poison value for illegal addresses.
  always_comb begin
    mrd_d_46 = '0;
    if (!rst_46 && mre_d_46) begin
      if (!ld_legal) begin
        mrd_d_46 = 32'hDEADBEEF;
      end else if (fwd_hit) begin
        mrd_d_46 = fwd_data;
      end else begin
        mrd_d_46 = mem_q[ld_idx];
      end
    end
  end

  // Buffer payload and array contents carry no reset; only valid entries are ever read.
  always_ff @(posedge clk_46) begin
    if (do_store) begin
      sb_idx_q[wr_ptr_q]  <= st_idx;
      sb_data_q[wr_ptr_q] <= mwd_d_46;
    end
    if (do_drain) begin
      mem_q[sb_idx_q[rd_ptr_q]] <= sb_data_q[rd_ptr_q];
    end
  end

  // Pointers, occupancy and the sticky address-error flag.
  always_ff @(posedge clk_46) begin
    if (rst_46) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (do_store) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_drain) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_store && !do_drain) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_store && do_drain) begin
        count_q <= count_q - CntW'(1);
      end
      if (bad_req) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  assign sb_count_46 = count_q;
  assign sb_full_46  = sb_full;
  assign addr_err_46 = addr_err_q;

`ifdef DMEM_SB_STATS_EN
  logic [15:0] ld_cnt_q, st_cnt_q, fwd_cnt_q;

  // Saturating activity counters.
  always_ff @(posedge clk_46) begin
    if (rst_46) begin
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
      fwd_cnt_q <= '0;
    end else begin
      if (do_load && (ld_cnt_q != 16'hFFFF)) begin
        ld_cnt_q <= ld_cnt_q + 16'd1;
      end
      if (do_store && (st_cnt_q != 16'hFFFF)) begin
        st_cnt_q <= st_cnt_q + 16'd1;
      end
      if (do_load && fwd_hit && (fwd_cnt_q != 16'hFFFF)) begin
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
      end
    end
  end

  assign ld_cnt_46  = ld_cnt_q;
  assign st_cnt_46  = st_cnt_q;
  assign fwd_cnt_46 = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_store_buffer_responder.sv
// Bench for dmem_store_buffer_responder: a queue-based reference model predicts each
// cycle's load data and buffer status; a monitor pops predictions and compares them.
module tb_dmem_store_buffer_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mwr = 1'b0;
  logic [31:0] mwa = '0;
  logic [31:0] mwd = '0;
  logic        mre = 1'b0;
  logic [31:0] mra = '0;
  logic [31:0] mrd;
  logic [2:0]  sb_count;
  logic        sb_full;
  logic        addr_err;

  always #5 clk = ~clk;

  dmem_store_buffer_responder dut (
    .clk_46      (clk),
    .rst_46      (rst),
    .mwr_d_46    (mwr),
    .mwa_d_46    (mwa),
    .mwd_d_46    (mwd),
    .mre_d_46    (mre),
    .mra_d_46    (mra),
    .mrd_d_46    (mrd),
    .sb_count_46 (sb_count),
    .sb_full_46  (sb_full),
    .addr_err_46 (addr_err)
  );

  typedef struct {
    int          id;
    logic [31:0] mrd;
    int          cnt;
    logic        full;
    logic        err;
  } exp_t;

  typedef struct {
    logic [7:0]  idx;
    logic [31:0] data;
  } ent_t;

  exp_t        exp_q[$];
  ent_t        m_sb[$];
  logic [31:0] m_mem [256];
  logic        m_err = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          ph = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input int id);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (phase %0d): got %08h expected %08h", name, id, act, exp);
    end
  endtask

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:10] == 22'd0);
  endfunction

  // One clock cycle: drive inputs, predict the observable outcome, advance the model.
  task automatic step(input logic r, input logic wr, input logic [31:0] wa,
                      input logic [31:0] wd, input logic re, input logic [31:0] ra);
    exp_t it;
    ent_t e;
    @(posedge clk);
    #1;
    rst = r; mwr = wr; mwa = wa; mwd = wd; mre = re; mra = ra;
    it.id   = ph;
    it.cnt  = m_sb.size();
    it.full = (m_sb.size() == 4);
    it.err  = m_err;
    it.mrd  = '0;
    if (r) begin
      m_sb.delete();
      m_err = 1'b0;
    end else begin
      if (re) begin
        if (!legal(ra)) begin
          it.mrd = 32'hDEADBEEF;
        end else begin
          it.mrd = m_mem[ra[9:2]];
          for (int i = 0; i < m_sb.size(); i++) begin
            if (m_sb[i].idx == ra[9:2]) it.mrd = m_sb[i].data;
          end
        end
      end
      if (m_sb.size() > 0 && (!re || m_sb.size() == 4)) begin
        e = m_sb.pop_front();
        m_mem[e.idx] = e.data;
      end
      if (wr && legal(wa)) begin
        e.idx  = wa[9:2];
        e.data = wd;
        m_sb.push_back(e);
      end
      if ((wr && !legal(wa)) || (re && !legal(ra))) m_err = 1'b1;
    end
    exp_q.push_back(it);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, '0);
  endtask

  task automatic st_ld(input logic [31:0] a, input logic [31:0] d, input logic [31:0] ra);
    step(1'b0, 1'b1, a, d, 1'b1, ra);
  endtask

  task automatic ld(input logic [31:0] ra);
    step(1'b0, 1'b0, '0, '0, 1'b1, ra);
  endtask

  function automatic logic [31:0] raddr();
    int unsigned r;
    logic [31:0] base;
    r    = $urandom_range(0, 19);
    base = 32'($urandom_range(0, 15)) << 2;
    if (r == 18) return base | 32'h2;
    if (r == 19) return base | 32'h400;
    return base;
  endfunction

  // Monitor: every cycle's prediction is compared mid-cycle, away from the clock edge.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        it = exp_q.pop_front();
        chk("mrd", mrd, it.mrd, it.id);
        chk("sb_count", 32'(sb_count), 32'(it.cnt), it.id);
        chk("sb_full", 32'(sb_full), 32'(it.full), it.id);
        chk("addr_err", 32'(addr_err), 32'(it.err), it.id);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    // Known array contents for every word.
    ph = 0;
    for (int i = 0; i < 256; i++) st(32'(i) << 2, 32'h1000_0000 + 32'(i));
    idle(2);

    ph = 1;  // reset, single store drains on the next idle cycle
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    st(32'h10, 32'hCAFE_0001);
    idle(2);
    ld(32'h10);

    ph = 2;  // continuous loads: fill, forced drain on fifth store, forward
    st_ld(32'h10, 32'hA000_0010, 32'h40);
    st_ld(32'h14, 32'hA000_0014, 32'h40);
    st_ld(32'h18, 32'hA000_0018, 32'h40);
    st_ld(32'h1C, 32'hA000_001C, 32'h40);
    st_ld(32'h20, 32'hA000_0020, 32'h40);
    ld(32'h20);
    ld(32'h10);
    idle(6);

    ph = 3;  // youngest of two stores to one index wins
    st_ld(32'h8, 32'h1111, 32'h40);
    st_ld(32'h8, 32'h2222, 32'h40);
    ld(32'h8);
    idle(4);
    ld(32'h8);

    ph = 4;  // same-cycle store and load see the old value
    st(32'hC, 32'h5555);
    idle(2);
    st_ld(32'hC, 32'hAAAA, 32'hC);
    ld(32'hC);
    idle(2);

    ph = 5;  // illegal addresses, sticky error
    st(32'h3, 32'hBAD0_0003);
    ld(32'h0001_0000);
    idle(3);
    ld(32'h0);

    ph = 6;  // reset discards pending stores
    st_ld(32'h30, 32'h3030, 32'h40);
    st_ld(32'h34, 32'h3434, 32'h40);
    st_ld(32'h38, 32'h3838, 32'h40);
    step(1'b1, 1'b1, 32'h3C, 32'h3C3C, 1'b1, 32'h30);
    ld(32'h30);
    ld(32'h34);
    ld(32'h38);
    idle(1);

    ph = 7;  // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, raddr(), $urandom(),
           $urandom_range(0, 9) < 7, raddr());
    end
    idle(6);
    for (int i = 0; i < 16; i++) ld(32'(i) << 2);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0, ph);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
